// File: rtl/blackbox_pkg.sv
// Shared definitions for the blackbox sweeper: state encoding and sweep sizes.
package blackbox_pkg;

  localparam int unsigned NUM_COMBOS = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned TABLE_W    = NUM_COMBOS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/sweep_ctrl.sv
// Sweep sequencer: walks idx through all combinations, holding each for
// SETTLE cycles (DRIVE) followed by one SAMPLE cycle.
module sweep_ctrl
  import blackbox_pkg::*;
#(
  parameter int unsigned SETTLE = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [IDX_W-1:0] idx,
  output logic             start_c,
  output logic             sample_c,
  output logic             last_c
);

  localparam int unsigned CW = $clog2(SETTLE + 1);

  state_t        state;
  logic [CW-1:0] cnt;

  // A start is honoured only when no sweep is in progress.
  assign start_c  = start && ((state == IDLE) || (state == DONE));
  assign sample_c = (state == SAMPLE);
  assign last_c   = (idx == IDX_W'(NUM_COMBOS - 1));

  // FSM with idx and settle counters; reset has priority over start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx   <= '0;
            cnt   <= '0;
            state <= DRIVE;
          end
        end
        DRIVE: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(SETTLE - 1)) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          cnt <= '0;
          if (last_c) begin
            state <= DONE;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/blackbox_sweep.sv
// Stimulus/capture wrapper for a 3-input blackbox: sweeps (y,t,e) through all
// combinations and captures n into an 8-bit truth table.
// Optional build macro BLACKBOX_SWEEP_COMPARE_EN adds a compare against
// expected_in, reporting mismatch/pass once the sweep completes.
module blackbox_sweep
  import blackbox_pkg::*;
#(
  parameter int unsigned SETTLE = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               n_in,
`ifdef BLACKBOX_SWEEP_COMPARE_EN
  input  logic [TABLE_W-1:0] expected_in,
  output logic [TABLE_W-1:0] mismatch,
  output logic               pass,
`endif
  output logic               y_out,
  output logic               t_out,
  output logic               e_out,
  output logic               busy,
  output logic               done,
  output logic [TABLE_W-1:0] table_out
);

  logic [IDX_W-1:0] idx;
  logic             start_c;
  logic             sample_c;
  logic             last_c;

  sweep_ctrl #(
    .SETTLE (SETTLE)
  ) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .idx      (idx),
    .start_c  (start_c),
    .sample_c (sample_c),
    .last_c   (last_c)
  );

  // Registered blackbox drive, status flags and truth-table capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_out     <= 1'b0;
      t_out     <= 1'b0;
      e_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= '0;
    end else if (start_c) begin
      {e_out, y_out, t_out} <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
      table_out <= '0;
    end else if (sample_c) begin
      table_out[idx] <= n_in;
      if (last_c) begin
        busy <= 1'b0;
        done <= 1'b1;
      end else begin
        {e_out, y_out, t_out} <= idx + IDX_W'(1);
      end
    end
  end

`ifdef BLACKBOX_SWEEP_COMPARE_EN
  logic [TABLE_W-1:0] table_next_c;
  logic [TABLE_W-1:0] diff_c;

  // Table as it will look after the final capture.
  always_comb begin
    table_next_c      = table_out;
    table_next_c[idx] = n_in;
    diff_c            = table_next_c ^ expected_in;
  end

  // Compare result latched on the transition into DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      mismatch <= '0;
      pass     <= 1'b0;
    end else if (sample_c && last_c) begin
      mismatch <= diff_c;
      pass     <= (diff_c == '0);
    end
  end
`endif

endmodule

// File: tb/tb_blackbox_sweep.sv
// Randomized scoreboard bench for blackbox_sweep with a behavioural blackbox.
module tb_blackbox_sweep;

  localparam int unsigned SETTLE = 10;
  localparam int unsigned PERIOD = SETTLE + 1;
  localparam int unsigned SWEEP  = 8 * PERIOD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       n_in;
  logic       y_out, t_out, e_out, busy, done;
  logic [7:0] table_out;
`ifdef BLACKBOX_SWEEP_COMPARE_EN
  logic [7:0] expected_in = 8'h00;
  logic [7:0] mismatch;
  logic       pass;
`endif

  always #5 clk = ~clk;

  blackbox_sweep #(.SETTLE(SETTLE)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .n_in        (n_in),
`ifdef BLACKBOX_SWEEP_COMPARE_EN
    .expected_in (expected_in),
    .mismatch    (mismatch),
    .pass        (pass),
`endif
    .y_out       (y_out),
    .t_out       (t_out),
    .e_out       (e_out),
    .busy        (busy),
    .done        (done),
    .table_out   (table_out)
  );

  // Sweep order as (y,t,e) triples, index i = position in the sweep.
  logic [2:0] order [8] = '{3'b000, 3'b010, 3'b100, 3'b110,
                            3'b001, 3'b011, 3'b101, 3'b111};

  int         mode = 0;      // 0 xor, 1 and, 2 const one, 3 lookup table
  logic [7:0] lut  = 8'h00;
  logic       noise = 1'b0;

  function automatic logic bb(int md, logic y, logic t, logic e, logic [7:0] lt);
    case (md)
      0:       return y ^ t ^ e;
      1:       return y & t & e;
      2:       return 1'b1;
      default: return lt[{e, y, t}];
    endcase
  endfunction

  function automatic logic [7:0] ref_table(int md, logic [7:0] lt);
    logic [7:0] r;
    logic [2:0] c;
    for (int i = 0; i < 8; i++) begin
      c    = order[i];
      r[i] = bb(md, c[2], c[1], c[0], lt);
    end
    return r;
  endfunction

  always_comb n_in = bb(mode, y_out, t_out, e_out, lut) ^ noise;

  // Reference model, advanced on each clock edge from the bench's own inputs.
  typedef struct packed {
    logic [7:0] tbl;
    logic [7:0] exp;
  } sb_t;

  sb_t         sb_q [$];
  int unsigned cyc  = 0;
  int          m_st = 0;     // 0 idle, 1 sweeping, 2 done
  int unsigned m_k  = 0;
  logic [7:0]  m_exp = 8'h00;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_st = 0;
      sb_q.delete();
    end else if (start && m_st != 1) begin
      m_st = 1;
      m_k  = cyc;
`ifdef BLACKBOX_SWEEP_COMPARE_EN
      m_exp = expected_in;
`endif
      sb_q.push_back('{tbl: ref_table(mode, lut), exp: m_exp});
    end else if (m_st == 1 && cyc == m_k + SWEEP) begin
      m_st = 2;
    end
  end

  // Garbage on n_in everywhere except the cycle that feeds a capture edge.
  always @(negedge clk) begin
    if (m_st == 1 && ((cyc - m_k) % PERIOD) == SETTLE) noise <= 1'b0;
    else noise <= 1'($urandom);
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: per-cycle status/drive checks, scoreboard pop on done rising.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    logic [2:0] exp_yte;
    sb_t        e;
    if (!reset) begin
      case (m_st)
        1:       exp_yte = order[(cyc - m_k) / PERIOD];
        2:       exp_yte = 3'b111;
        default: exp_yte = 3'b000;
      endcase
      check("yte", 32'({y_out, t_out, e_out}), 32'(exp_yte));
      check("busy", 32'(busy), 32'(m_st == 1));
      check("done", 32'(done), 32'(m_st == 2));
      if (m_st == 0 || (m_st == 1 && cyc == m_k))
        check("table_clear", 32'(table_out), 32'h0);
      if (done && !prev_done) begin
        if (sb_q.size() == 0) begin
          check("sb_empty", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check("table", 32'(table_out), 32'(e.tbl));
          check("done_cycle", cyc - m_k, SWEEP);
`ifdef BLACKBOX_SWEEP_COMPARE_EN
          check("mismatch", 32'(mismatch), 32'(e.tbl ^ e.exp));
          check("pass", 32'(pass), 32'(e.tbl == e.exp));
`endif
        end
      end
    end
    prev_done = done;
  end

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 300);
    if (!done) check("done_timeout", 32'(done), 32'd1);
    cycles(2);
  endtask

  initial begin
    cycles(2);
    check("rst_table", 32'(table_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_yte", 32'({y_out, t_out, e_out}), 32'h0);
    reset = 1'b0;
    cycles(3);

    mode = 0;
`ifdef BLACKBOX_SWEEP_COMPARE_EN
    expected_in = 8'h96;
`endif
    pulse_start();
    wait_done();
    check("xor_table", 32'(table_out), 32'h96);

    mode = 1;
`ifdef BLACKBOX_SWEEP_COMPARE_EN
    expected_in = 8'h97;
`endif
    pulse_start();
    wait_done();
    check("and_table", 32'(table_out), 32'h80);

    mode = 2;
    pulse_start();
    wait_done();
    check("one_table", 32'(table_out), 32'hFF);

    // Restart attempt mid-sweep is ignored.
    mode = 0;
`ifdef BLACKBOX_SWEEP_COMPARE_EN
    expected_in = 8'h97;
`endif
    pulse_start();
    cycles(28);
    pulse_start();
    wait_done();

    // Reset mid-sweep discards the partial table.
    pulse_start();
    cycles(38);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("midrst_table", 32'(table_out), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    pulse_start();
    wait_done();

    // start and reset together: reset wins.
    @(negedge clk); start = 1'b1; reset = 1'b1;
    @(negedge clk); start = 1'b0; reset = 1'b0;
    check("rs_busy", 32'(busy), 32'h0);
    check("rs_done", 32'(done), 32'h0);
    cycles(3);

    // Randomized sweeps with occasional ignored restarts and resets.
    for (int r = 0; r < 10; r++) begin
      mode = int'($urandom_range(0, 3));
      lut  = 8'($urandom);
`ifdef BLACKBOX_SWEEP_COMPARE_EN
      expected_in = ($urandom_range(0, 1) == 1) ? ref_table(mode, lut) : 8'($urandom);
`endif
      pulse_start();
      case ($urandom_range(0, 2))
        0: begin cycles(int'($urandom_range(1, 80))); pulse_start(); end
        1: begin
          cycles(int'($urandom_range(1, 80)));
          @(negedge clk); reset = 1'b1;
          @(negedge clk); reset = 1'b0;
          pulse_start();
        end
        default: ;
      endcase
      wait_done();
    end

    cycles(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
